uart_tx_engine: RTL and testbench

//   Parametrised UART transmit engine: FSM, serializer, bit counter and parity generator in one block.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_engine_if.sv | 31 +++
 rtl/uart_tx_serializer.sv | 41 ++++
 rtl/uart_tx_engine.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_engine.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and parity selectors.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_engine_if.sv
// Word handshake and per-frame configuration between the TX FIFO/register side and the engine.
interface uart_tx_engine_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  DATA_READY;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP2;

  modport master (
    output P_DATA,
    output DATA_VALID,
    output PAR_EN,
    output PAR_TYP,
    output STOP2,
    input  DATA_READY
  );

  modport slave (
    input  P_DATA,
    input  DATA_VALID,
    input  PAR_EN,
    input  PAR_TYP,
    input  STOP2,
    output DATA_READY
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// LSB-first payload shifter with bit counter; the FSM decides when to load and advance.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  first,
  input  logic                  shift,
  output logic                  bit_out,
  output logic                  last_bit
);

  logic [DATA_WIDTH-1:0] sh_q;
  logic [CNT_WIDTH-1:0]  bit_cnt_q;

  // sh_q[0] always holds the next bit to put on the line
  always_ff @(posedge CLK) begin
    if (load) begin
      sh_q <= load_data;
    end else if (first || shift) begin
      sh_q <= sh_q >> 1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt_q <= '0;
    end else if (first) begin
      bit_cnt_q <= '0;
    end else if (shift) begin
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

  assign bit_out  = sh_q[0];
  assign last_bit = (bit_cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: frame FSM, parity, stop-bit counting and registered line outputs.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               TICK,
  uart_tx_engine_if.slave    bus,
  output logic               TX_OUT,
  output logic               BUSY,
  output logic               DONE
);

  function automatic logic frame_parity(input logic [DATA_WIDTH-1:0] d, input logic typ);
    logic p;
    p = ^d;
    case (typ)
      PAR_EVEN: frame_parity = p;
      PAR_ODD:  frame_parity = ~p;
      default:  frame_parity = p;
    endcase
  endfunction

  tx_state_t state_q, state_d;
  logic      tx_q, tx_d;
  logic      busy_q, busy_d;
  logic      done_q, done_d;
  logic      stop_cnt_q, stop_cnt_d;
  logic      par_en_q, stop2_q, par_bit_q;
  logic      stop_last, ready, take;
  logic      ser_first, ser_shift, ser_bit, ser_last;

  // Last stop bit: the only one with STOP2 clear, the second one otherwise
  assign stop_last = stop2_q ? stop_cnt_q : 1'b1;
  assign ready     = (state_q == IDLE) || ((state_q == STOP) && stop_last && TICK);
  assign take      = ready && bus.DATA_VALID;

  assign bus.DATA_READY = ready;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_ser (
    .CLK       (CLK),
    .RST       (RST),
    .load      (take),
    .load_data (bus.P_DATA),
    .first     (ser_first),
    .shift     (ser_shift),
    .bit_out   (ser_bit),
    .last_bit  (ser_last)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    stop_cnt_d = stop_cnt_q;
    ser_first  = 1'b0;
    ser_shift  = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = ARM;
          busy_d  = 1'b1;
        end
      end
      ARM: begin
        if (TICK) begin
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (TICK) begin
          state_d   = DATA;
          tx_d      = ser_bit;
          ser_first = 1'b1;
        end
      end
      DATA: begin
        if (TICK) begin
          if (!ser_last) begin
            tx_d      = ser_bit;
            ser_shift = 1'b1;
          end else if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d    = STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
          end
        end
      end
      PARITY: begin
        if (TICK) begin
          state_d    = STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (TICK) begin
          if (!stop_last) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_d = 1'b1;
            // A word waiting at the end of the stop bit starts the next frame with no idle gap
            if (bus.DATA_VALID) begin
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stop_cnt_q <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      stop_cnt_q <= stop_cnt_d;
      if (take) begin
        par_en_q <= bus.PAR_EN;
        stop2_q  <= bus.STOP2;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (take) begin
      par_bit_q <= frame_parity(bus.P_DATA, bus.PAR_TYP);
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: frame-list reference model compared every cycle, plus literal frame checks.
module tb_uart_tx_engine;
  import uart_pkg::*;

  logic CLK;
  logic RST;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  logic       tick    [2];
  logic       valid   [2];
  logic [8:0] pdata   [2];
  logic       par_en  [2];
  logic       par_typ [2];
  logic       stop2   [2];
  int         tick_per[2];
  int         tick_cnt[2];

  logic tx8, busy8, done8, tx5, busy5, done5;

  uart_tx_engine_if #(.DATA_WIDTH(8)) if8 ();
  uart_tx_engine_if #(.DATA_WIDTH(5)) if5 ();

  assign if8.P_DATA     = pdata[0][7:0];
  assign if8.DATA_VALID = valid[0];
  assign if8.PAR_EN     = par_en[0];
  assign if8.PAR_TYP    = par_typ[0];
  assign if8.STOP2      = stop2[0];
  assign if5.P_DATA     = pdata[1][4:0];
  assign if5.DATA_VALID = valid[1];
  assign if5.PAR_EN     = par_en[1];
  assign if5.PAR_TYP    = par_typ[1];
  assign if5.STOP2      = stop2[1];

  uart_tx_engine #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut8 (
    .CLK(CLK), .RST(RST), .TICK(tick[0]), .bus(if8),
    .TX_OUT(tx8), .BUSY(busy8), .DONE(done8)
  );

  uart_tx_engine #(.DATA_WIDTH(5), .CNT_WIDTH(3)) dut5 (
    .CLK(CLK), .RST(RST), .TICK(tick[1]), .bus(if5),
    .TX_OUT(tx5), .BUSY(busy5), .DONE(done5)
  );

  function automatic logic o_tx(int i);   return (i == 0) ? tx8 : tx5; endfunction
  function automatic logic o_busy(int i); return (i == 0) ? busy8 : busy5; endfunction
  function automatic logic o_done(int i); return (i == 0) ? done8 : done5; endfunction
  function automatic logic o_rdy(int i);  return (i == 0) ? if8.DATA_READY : if5.DATA_READY; endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: each accepted word becomes a list of line levels, one per TICK period
  int         mw [2] = '{8, 5};
  logic       m_busy [2];
  logic       m_arm  [2];
  logic       m_line [2];
  logic       m_done [2];
  logic       m_took [2];
  logic [15:0] m_frame [2];
  int         m_left [2];

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_arm[i] = 1'b0; m_line[i] = 1'b1;
      m_done[i] = 1'b0; m_took[i] = 1'b0; m_frame[i] = '0; m_left[i] = 0;
    end
  endtask

  task automatic m_load(int i);
    logic [15:0] v;
    int n, ones;
    v = '0; n = 1; ones = 0;
    for (int b = 0; b < mw[i]; b++) begin
      v[n] = pdata[i][b];
      if (pdata[i][b]) ones++;
      n++;
    end
    if (par_en[i]) begin
      v[n] = ((ones % 2) == 1) ^ (par_typ[i] == PAR_ODD);
      n++;
    end
    v[n] = 1'b1; n++;
    if (stop2[i]) begin v[n] = 1'b1; n++; end
    m_frame[i] = v;
    m_left[i]  = n;
    m_took[i]  = 1'b1;
  endtask

  task automatic m_pop(int i);
    m_line[i]  = m_frame[i][0];
    m_frame[i] = m_frame[i] >> 1;
    m_left[i]--;
  endtask

  function automatic logic m_ready(int i);
    return !m_busy[i] || (!m_arm[i] && m_left[i] == 0 && tick[i]);
  endfunction

  task automatic m_step(int i);
    m_done[i] = 1'b0;
    m_took[i] = 1'b0;
    if (!m_busy[i]) begin
      if (valid[i]) begin
        m_load(i);
        m_busy[i] = 1'b1;
        m_arm[i]  = 1'b1;
      end
    end else if (tick[i]) begin
      if (m_arm[i]) begin
        m_arm[i] = 1'b0;
        m_pop(i);
      end else if (m_left[i] > 0) begin
        m_pop(i);
      end else begin
        m_done[i] = 1'b1;
        if (valid[i]) begin
          m_load(i);
          m_pop(i);
        end else begin
          m_busy[i] = 1'b0;
          m_line[i] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) m_reset();
      else for (int i = 0; i < 2; i++) m_step(i);
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("tx%0d", i),    o_tx(i),   m_line[i]);
        chk($sformatf("busy%0d", i),  o_busy(i), m_busy[i]);
        chk($sformatf("done%0d", i),  o_done(i), m_done[i]);
        chk($sformatf("ready%0d", i), o_rdy(i),  m_ready(i));
      end
    end
  end

  // Observed line level right after every TICK edge of a busy frame
  int   cur = 0;
  logic line_log[$];
  int   done_cnt, busy_cyc, busy_falls;
  logic prev_busy = 1'b0;

  initial begin
    logic t_s, b_s;
    forever begin
      @(posedge CLK);
      t_s = tick[cur];
      b_s = o_busy(cur);
      @(negedge CLK);
      if (t_s && b_s) line_log.push_back(o_tx(cur));
      if (o_done(cur)) done_cnt++;
      if (o_busy(cur)) busy_cyc++;
      if (prev_busy && !o_busy(cur)) busy_falls++;
      prev_busy = o_busy(cur);
    end
  end

  task automatic clr_rec();
    line_log.delete();
    done_cnt = 0; busy_cyc = 0; busy_falls = 0;
  endtask

  task automatic chk_seq(input string name, input string exp);
    string act;
    act = "";
    foreach (line_log[k]) act = {act, (line_log[k] ? "1" : "0")};
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: line bits %s, want %s", name, act, exp);
    end
  endtask

  initial begin
    tick[0] = 1'b0; tick[1] = 1'b0;
    tick_cnt[0] = 0; tick_cnt[1] = 0;
    forever begin
      @(posedge CLK); #1;
      for (int i = 0; i < 2; i++) begin
        if (tick_per[i] == 0) tick[i] = 1'b0;
        else begin
          tick_cnt[i]++;
          tick[i] = ((tick_cnt[i] % tick_per[i]) == 0);
        end
      end
    end
  end

  task automatic send(input int i, input logic [8:0] d, input logic pe, input logic pt, input logic s2);
    logic got;
    @(posedge CLK); #1;
    pdata[i] = d; par_en[i] = pe; par_typ[i] = pt; stop2[i] = s2; valid[i] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 600 && !got; k++) begin
      @(posedge CLK); #1;
      if (m_took[i]) got = 1'b1;
    end
    valid[i] = 1'b0;
    chk("send_accept", got, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000 && m_busy[cur]; k++) @(negedge CLK);
    chk("idle_busy", o_busy(cur), 0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic wait_log(input int n);
    for (int k = 0; k < 2000 && line_log.size() < n; k++) @(negedge CLK);
    chk("wait_log", (line_log.size() >= n) ? 1 : 0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0; pdata[i] = '0; par_en[i] = 1'b0; par_typ[i] = PAR_EVEN;
      stop2[i] = 1'b0; tick_per[i] = 0;
    end
    repeat (3) @(negedge CLK);
    chk("rst_tx", tx8, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_ready", if8.DATA_READY, 1);
    @(posedge CLK); #1 RST = 1'b0;
    tick_per[0] = 4;

    // basic frame, no parity, one stop bit
    clr_rec();
    send(0, 9'h0A5, 1'b0, PAR_EVEN, 1'b0);
    wait_idle();
    chk_seq("t1_frame", "01010010111");
    chk("t1_done", done_cnt, 1);

    // parity variants
    clr_rec();
    send(0, 9'h007, 1'b1, PAR_EVEN, 1'b0);
    wait_idle();
    chk_seq("t2_even07", "011100000111");
    clr_rec();
    send(0, 9'h007, 1'b1, PAR_ODD, 1'b0);
    wait_idle();
    chk_seq("t2_odd07", "011100000011");
    clr_rec();
    send(0, 9'h000, 1'b1, PAR_ODD, 1'b0);
    wait_idle();
    chk_seq("t2_odd00", "000000000111");
    clr_rec();
    send(0, 9'h007, 1'b0, PAR_ODD, 1'b0);
    wait_idle();
    chk_seq("t2_nopar", "01110000011");

    // two stop bits and a zero-gap second frame
    clr_rec();
    send(0, 9'h03C, 1'b0, PAR_EVEN, 1'b1);
    send(0, 9'h0C3, 1'b0, PAR_EVEN, 1'b1);
    wait_idle();
    chk_seq("t3_b2b", "00011110011011000011111");
    chk("t3_done", done_cnt, 2);
    chk("t3_busy_falls", busy_falls, 1);

    // valid while busy is ignored
    clr_rec();
    send(0, 9'h05A, 1'b1, PAR_EVEN, 1'b0);
    wait_log(4);
    @(posedge CLK); #1;
    pdata[0] = 9'h0FF; par_typ[0] = PAR_ODD; valid[0] = 1'b1;
    @(negedge CLK);
    chk("t4_ready_busy", if8.DATA_READY, 0);
    @(posedge CLK); #1 valid[0] = 1'b0;
    wait_idle();
    chk_seq("t4_frame", "001011010011");
    chk("t4_done", done_cnt, 1);

    // reset during data bit 3
    clr_rec();
    send(0, 9'h055, 1'b0, PAR_EVEN, 1'b0);
    wait_log(5);
    #1 RST = 1'b1;
    #1;
    chk("t5_rst_tx", tx8, 1);
    chk("t5_rst_busy", busy8, 0);
    chk("t5_rst_done", done8, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (6) @(negedge CLK);
    chk("t5_no_resume", busy8, 0);
    clr_rec();
    send(0, 9'h055, 1'b0, PAR_EVEN, 1'b0);
    wait_idle();
    chk_seq("t5_frame", "01010101011");

    // 5-bit engine, TICK every cycle
    tick_per[0] = 0;
    cur = 1;
    tick_per[1] = 1;
    repeat (2) @(negedge CLK);
    clr_rec();
    send(1, 9'h01F, 1'b1, PAR_EVEN, 1'b0);
    wait_idle();
    chk_seq("t6_frame", "011111111");
    chk("t6_done", done_cnt, 1);
    chk("t6_busy_cycles", busy_cyc, 9);

    repeat (4) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
